// File: rtl/reg_file_scoreboard.sv
// Register file with write-through bypass and a per-register pending
// scoreboard that flags RAW/WAW hazards for the issue stage.
module reg_file_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic [DATA_WIDTH-1:0] rd2_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  issue_use_rs1,
  input  logic                  issue_use_rs2,
  output logic                  hazard,
  output logic [ADDR_WIDTH:0]   pending_count
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_nxt;
  logic [ADDR_WIDTH:0]   count_nxt;

  logic wr_ok;
  logic clr_rs1;
  logic clr_rs2;
  logic clr_rd;
  logic haz_rs1;
  logic haz_rs2;
  logic haz_rd;
  logic accept;

  assign wr_ok   = wr_en && (wr_addr != '0);
  assign clr_rs1 = wr_en && (wr_addr == rs1_addr);
  assign clr_rs2 = wr_en && (wr_addr == rs2_addr);
  assign clr_rd  = wr_en && (wr_addr == issue_rd);

  assign haz_rs1 = issue_use_rs1 && pending[rs1_addr] && !clr_rs1;
  assign haz_rs2 = issue_use_rs2 && pending[rs2_addr] && !clr_rs2;
  assign haz_rd  = (issue_rd != '0) && pending[issue_rd] && !clr_rd;

  assign hazard = issue_valid && (haz_rs1 || haz_rs2 || haz_rd);
  assign accept = issue_valid && !hazard;

  // x0 is hardwired; the bypass only applies to real registers
  always_comb begin
    rd1_data = regs[rs1_addr];
    rd2_data = regs[rs2_addr];
    if (rs1_addr == '0) rd1_data = '0;
    else if (clr_rs1)   rd1_data = wr_data;
    if (rs2_addr == '0) rd2_data = '0;
    else if (clr_rs2)   rd2_data = wr_data;
  end

  // set after clear so a same-cycle issue keeps the register pending
  always_comb begin
    pending_nxt = pending;
    if (wr_ok) pending_nxt[wr_addr] = 1'b0;
    if (accept && (issue_rd != '0)) pending_nxt[issue_rd] = 1'b1;
    count_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      count_nxt = count_nxt + (ADDR_WIDTH+1)'(pending_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pending       <= '0;
      pending_count <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      pending       <= pending_nxt;
      pending_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard; expectations are queued by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rd1_data;
  logic [31:0] rd2_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_use_rs1;
  logic        issue_use_rs2;
  logic        hazard;
  logic [5:0]  pending_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  reg_file_scoreboard dut (
    .clk(clk),
    .rst(rst),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rd1_data(rd1_data),
    .rd2_data(rd2_data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2),
    .hazard(hazard),
    .pending_count(pending_count)
  );

  task automatic expect_v(input int kind, input logic [31:0] val,
                          input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rs1_addr      = '0;
    rs2_addr      = '0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    issue_valid   = 1'b0;
    issue_rd      = '0;
    issue_use_rs1 = 1'b0;
    issue_use_rs2 = 1'b0;
  endtask

  // kinds: 0 rd1, 1 rd2, 2 hazard, 3 pending_count
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = q.pop_front();
        unique case (e.kind)
          0: act = rd1_data;
          1: act = rd2_data;
          2: act = {31'd0, hazard};
          default: act = {26'd0, pending_count};
        endcase
        total++;
        if (act !== e.val) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    rs1_addr = '0; rs2_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state across every index
    for (int i = 0; i < 32; i++) begin
      step();
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      expect_v(0, 32'h0, "reset_rd1");
      expect_v(1, 32'h0, "reset_rd2");
      if (i == 0) begin
        expect_v(2, 32'h0, "reset_hazard");
        expect_v(3, 32'h0, "reset_count");
      end
    end

    // write then read, x0 ignores writes
    step();
    wr_en = 1; wr_addr = 5; wr_data = 32'h0000_00AA;
    step();
    rs1_addr = 5;
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
    expect_v(0, 32'hAA, "read_x5");
    expect_v(1, 32'h0, "x0_bypass");
    step();
    rs1_addr = 5;
    expect_v(0, 32'hAA, "x5_hold");
    expect_v(1, 32'h0, "x0_stored");

    // write-through bypass on both ports
    step();
    wr_en = 1; wr_addr = 7; wr_data = 32'h1234;
    rs1_addr = 7; rs2_addr = 7;
    expect_v(0, 32'h1234, "bypass_rd1");
    expect_v(1, 32'h1234, "bypass_rd2");
    step();
    rs1_addr = 7; rs2_addr = 7;
    expect_v(0, 32'h1234, "stored_rd1");
    expect_v(1, 32'h1234, "stored_rd2");

    // RAW on x3 resolved by same-cycle writeback
    step();
    issue_valid = 1; issue_rd = 3;
    expect_v(2, 32'h0, "issue3_ok");
    expect_v(3, 32'h0, "count_pre3");
    step();
    issue_valid = 1; issue_use_rs1 = 1; rs1_addr = 3;
    expect_v(2, 32'h1, "raw_x3");
    expect_v(3, 32'h1, "count_x3");
    step();
    issue_valid = 1; issue_use_rs1 = 1; rs1_addr = 3;
    wr_en = 1; wr_addr = 3; wr_data = 32'h55;
    expect_v(2, 32'h0, "raw_x3_clr");
    expect_v(0, 32'h55, "raw_x3_byp");
    expect_v(3, 32'h1, "count_x3_hold");
    step();
    expect_v(3, 32'h0, "count_x3_done");
    expect_v(2, 32'h0, "idle_hazard");

    // issue and write to x4 together: set wins
    step();
    issue_valid = 1; issue_rd = 4;
    wr_en = 1; wr_addr = 4; wr_data = 32'h44;
    expect_v(2, 32'h0, "issue4_ok");
    step();
    rs1_addr = 4;
    expect_v(0, 32'h44, "x4_data");
    expect_v(3, 32'h1, "count_x4");
    step();
    issue_valid = 1; issue_rd = 4;
    expect_v(2, 32'h1, "waw_x4_a");
    step();
    issue_valid = 1; issue_rd = 4;
    expect_v(2, 32'h1, "waw_x4_b");
    step();
    issue_valid = 1; issue_rd = 4;
    wr_en = 1; wr_addr = 4; wr_data = 32'h99;
    expect_v(2, 32'h0, "waw_x4_clr");
    step();
    rs1_addr = 4;
    expect_v(0, 32'h99, "x4_rewritten");
    expect_v(3, 32'h1, "count_x4_reset");
    step();
    wr_en = 1; wr_addr = 4; wr_data = 32'h1;
    step();
    expect_v(3, 32'h0, "count_x4_done");

    // rs2 hazard, then async reset in mid-cycle
    step();
    wr_en = 1; wr_addr = 9; wr_data = 32'h77;
    step();
    issue_valid = 1; issue_rd = 9;
    step();
    issue_valid = 1; issue_rd = 10;
    expect_v(3, 32'h1, "count_9");
    step();
    issue_valid = 1; issue_use_rs2 = 1; rs2_addr = 9;
    expect_v(2, 32'h1, "raw_rs2_x9");
    expect_v(3, 32'h2, "count_9_10");
    step();
    issue_valid = 1; issue_use_rs1 = 1; rs1_addr = 9; issue_rd = 11;
    #2 rst = 1'b1;
    expect_v(3, 32'h0, "rst_count");
    expect_v(0, 32'h0, "rst_x9");
    expect_v(2, 32'h0, "rst_hazard");
    step();
    rst = 1'b0;
    rs1_addr = 9; rs2_addr = 5;
    issue_valid = 1; issue_rd = 9;
    expect_v(3, 32'h0, "post_rst_count");
    expect_v(0, 32'h0, "post_rst_x9");
    expect_v(1, 32'h0, "post_rst_x5");
    expect_v(2, 32'h0, "post_rst_hazard");
    step();
    expect_v(3, 32'h1, "post_rst_issue");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending checks want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
